// File: rtl/disp_timing_gen_pkg.sv
// Shared types and helpers for the raster timing generator.
package disp_timing_pkg;

  localparam int PW  = 6;
  localparam int CW  = 9;
  localparam int FCW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [PW-1:0] vsw;
    logic [PW-1:0] vbp;
    logic [PW-1:0] vact;
    logic [PW-1:0] vfp;
    logic [PW-1:0] hsw;
    logic [PW-1:0] hbp;
    logic [PW-1:0] hact;
    logic [PW-1:0] hfp;
  } porch_cfg_t;

  function automatic logic [CW-1:0] h_total(input porch_cfg_t c);
    return CW'(c.hsw) + CW'(c.hbp) + CW'(c.hact) + CW'(c.hfp);
  endfunction

  function automatic logic [CW-1:0] v_total(input porch_cfg_t c);
    return CW'(c.vsw) + CW'(c.vbp) + CW'(c.vact) + CW'(c.vfp);
  endfunction

  function automatic logic cfg_valid(input porch_cfg_t c);
    return (c.hsw != '0) && (c.hact != '0) && (c.vsw != '0) && (c.vact != '0) &&
           (h_total(c) >= CW'(4)) && (v_total(c) >= CW'(2));
  endfunction

endpackage

// File: rtl/disp_timing_gen_cfg_regs.sv
// Active/pending porch configuration with frame-boundary swap.
module disp_timing_cfg_regs
  import disp_timing_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  input  logic          idle,
  input  logic          load,
  input  logic          frame_end,
  input  logic          halt,
  input  porch_cfg_t    cfg_in,
  output logic [CW-1:0] htot,
  output logic [CW-1:0] vtot,
  output logic [CW-1:0] hsw,
  output logic [CW-1:0] vsw,
  output logic [CW-1:0] h_de_lo,
  output logic [CW-1:0] h_de_hi,
  output logic [CW-1:0] v_de_lo,
  output logic [CW-1:0] v_de_hi,
  output logic          cfg_err,
  output logic          swap_err
);

  porch_cfg_t act_q;
  porch_cfg_t pend_q;
  logic       pend_valid;

  // Direct writes while idle; double-buffered writes while a frame is in flight.
  // A load on a halting frame-end cycle goes straight to active, so nothing is
  // ever left pending while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_q      <= '0;
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else if (idle) begin
      if (load) act_q <= cfg_in;
    end else if (frame_end) begin
      pend_valid <= 1'b0;
      if (load && halt) begin
        act_q <= cfg_in;
      end else begin
        if (pend_valid) act_q <= pend_q;
        if (load) begin
          pend_q     <= cfg_in;
          pend_valid <= 1'b1;
        end
      end
    end else if (load) begin
      pend_q     <= cfg_in;
      pend_valid <= 1'b1;
    end
  end

  // Timing bounds and validity derived from the active and pending configs
  always_comb begin
    htot     = h_total(act_q);
    vtot     = v_total(act_q);
    hsw      = CW'(act_q.hsw);
    vsw      = CW'(act_q.vsw);
    h_de_lo  = CW'(act_q.hsw) + CW'(act_q.hbp);
    h_de_hi  = h_de_lo + CW'(act_q.hact);
    v_de_lo  = CW'(act_q.vsw) + CW'(act_q.vbp);
    v_de_hi  = v_de_lo + CW'(act_q.vact);
    cfg_err  = !cfg_valid(act_q);
    swap_err = pend_valid ? !cfg_valid(pend_q) : cfg_err;
  end

endmodule

// File: rtl/disp_timing_gen.sv
// Programmable raster timing generator (vsync/hsync/de, 1-based counters).
module disp_timing_gen
  import disp_timing_pkg::*;
#(
  parameter int PW  = 6,
  parameter int CW  = 9,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_enable,
  input  logic           i_cfg_load,
  input  logic [PW-1:0]  i_VSW,
  input  logic [PW-1:0]  i_VBP,
  input  logic [PW-1:0]  i_VACT,
  input  logic [PW-1:0]  i_VFP,
  input  logic [PW-1:0]  i_HSW,
  input  logic [PW-1:0]  i_HBP,
  input  logic [PW-1:0]  i_HACT,
  input  logic [PW-1:0]  i_HFP,
  output logic           o_vsync,
  output logic           o_hsync,
  output logic           o_de,
  output logic [CW-1:0]  o_h_cnt,
  output logic [CW-1:0]  o_v_cnt,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic           o_busy,
  output logic [FCW-1:0] o_frame_cnt,
  output logic           o_cfg_err
);

  state_t        state_q, state_nx;
  porch_cfg_t    cfg_in;
  logic [CW-1:0] htot, vtot, hsw, vsw, h_de_lo, h_de_hi, v_de_lo, v_de_hi;
  logic          swap_err, line_end, frame_end;
  logic [CW-1:0] h_nx, v_nx;
  logic          hs_nx, vs_nx, de_nx, ls_nx, fs_nx;

  assign cfg_in.vsw  = i_VSW;
  assign cfg_in.vbp  = i_VBP;
  assign cfg_in.vact = i_VACT;
  assign cfg_in.vfp  = i_VFP;
  assign cfg_in.hsw  = i_HSW;
  assign cfg_in.hbp  = i_HBP;
  assign cfg_in.hact = i_HACT;
  assign cfg_in.hfp  = i_HFP;

  assign line_end  = (o_h_cnt >= htot);
  assign frame_end = (state_q != IDLE) && line_end && (o_v_cnt >= vtot);
  assign o_busy    = (state_q != IDLE);

  disp_timing_cfg_regs u_cfg (
    .clk       (clk),
    .resetn    (resetn),
    .idle      (state_q == IDLE),
    .load      (i_cfg_load),
    .frame_end (frame_end),
    .halt      (state_nx == IDLE),
    .cfg_in    (cfg_in),
    .htot      (htot),
    .vtot      (vtot),
    .hsw       (hsw),
    .vsw       (vsw),
    .h_de_lo   (h_de_lo),
    .h_de_hi   (h_de_hi),
    .v_de_lo   (v_de_lo),
    .v_de_hi   (v_de_hi),
    .cfg_err   (o_cfg_err),
    .swap_err  (swap_err)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_nx;
  end

  // Next state: frames are only ever abandoned at their final pixel
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:      if (i_enable && !o_cfg_err) state_nx = RUN;
      RUN, STOP: begin
        if (frame_end) state_nx = (i_enable && !swap_err) ? RUN : IDLE;
        else           state_nx = i_enable ? RUN : STOP;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // Next counter and strobe values. The first pixel of a frame is decoded with
  // the outgoing config; that is exact because h=1,v=1 always gives sync=1,
  // de=0 for any valid config.
  always_comb begin
    h_nx = '0;
    v_nx = '0;
    if (state_nx != IDLE) begin
      if (state_q == IDLE || frame_end) begin
        h_nx = CW'(1);
        v_nx = CW'(1);
      end else if (line_end) begin
        h_nx = CW'(1);
        v_nx = o_v_cnt + CW'(1);
      end else begin
        h_nx = o_h_cnt + CW'(1);
        v_nx = o_v_cnt;
      end
    end
    hs_nx = (h_nx != '0) && (h_nx <= hsw);
    vs_nx = (v_nx != '0) && (v_nx <= vsw);
    de_nx = (h_nx > h_de_lo) && (h_nx <= h_de_hi) && (v_nx > v_de_lo) && (v_nx <= v_de_hi);
    ls_nx = (h_nx == CW'(1));
    fs_nx = ls_nx && (v_nx == CW'(1));
  end

  // Registered counters, strobes and frame count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_h_cnt       <= '0;
      o_v_cnt       <= '0;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_de          <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_h_cnt       <= h_nx;
      o_v_cnt       <= v_nx;
      o_hsync       <= hs_nx;
      o_vsync       <= vs_nx;
      o_de          <= de_nx;
      o_line_start  <= ls_nx;
      o_frame_start <= fs_nx;
      if (frame_end) o_frame_cnt <= o_frame_cnt + FCW'(1);
    end
  end

endmodule

// File: tb/tb_disp_timing_gen.sv
// Self-checking bench for disp_timing_gen against a frame-level reference model.
module tb_disp_timing_gen;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_cfg_load = 1'b0;
  logic [5:0] i_VSW, i_VBP, i_VACT, i_VFP, i_HSW, i_HBP, i_HACT, i_HFP;
  logic       o_vsync, o_hsync, o_de, o_line_start, o_frame_start, o_busy, o_cfg_err;
  logic [8:0] o_h_cnt, o_v_cnt;
  logic [7:0] o_frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Config arrays: 0 HSW, 1 HBP, 2 HACT, 3 HFP, 4 VSW, 5 VBP, 6 VACT, 7 VFP
  int cin[8];
  int act[8];
  int pend[8];
  bit m_run, m_pv;
  int m_h, m_v, m_fc;

  assign i_HSW  = 6'(cin[0]);
  assign i_HBP  = 6'(cin[1]);
  assign i_HACT = 6'(cin[2]);
  assign i_HFP  = 6'(cin[3]);
  assign i_VSW  = 6'(cin[4]);
  assign i_VBP  = 6'(cin[5]);
  assign i_VACT = 6'(cin[6]);
  assign i_VFP  = 6'(cin[7]);

  always #5 clk = ~clk;

  disp_timing_gen #(.PW(6), .CW(9), .FCW(8)) dut (
    .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_cfg_load(i_cfg_load),
    .i_VSW(i_VSW), .i_VBP(i_VBP), .i_VACT(i_VACT), .i_VFP(i_VFP),
    .i_HSW(i_HSW), .i_HBP(i_HBP), .i_HACT(i_HACT), .i_HFP(i_HFP),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_h_cnt(o_h_cnt), .o_v_cnt(o_v_cnt),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_cfg_err(o_cfg_err)
  );

  function automatic int htot(input int c[8]);
    return c[0] + c[1] + c[2] + c[3];
  endfunction

  function automatic int vtot(input int c[8]);
    return c[4] + c[5] + c[6] + c[7];
  endfunction

  function automatic bit valid(input int c[8]);
    return c[0] > 0 && c[2] > 0 && c[4] > 0 && c[6] > 0 && htot(c) >= 4 && vtot(c) >= 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_h = 0; m_v = 0; m_fc = 0;
    for (int i = 0; i < 8; i++) begin act[i] = 0; pend[i] = 0; end
  endtask

  // One clock edge of the frame-level behaviour, using the inputs present at the edge
  task automatic model_edge();
    bit halt;
    if (!m_run) begin
      halt = !(i_enable && valid(act));
      if (i_cfg_load) act = cin;
      if (!halt) begin m_run = 1; m_h = 1; m_v = 1; end
    end else if (m_h >= htot(act) && m_v >= vtot(act)) begin
      m_fc++;
      if (m_pv) act = pend;
      m_pv = 0;
      halt = !i_enable || !valid(act);
      if (i_cfg_load) begin
        if (halt) act = cin;
        else begin pend = cin; m_pv = 1; end
      end
      if (halt) begin m_run = 0; m_h = 0; m_v = 0; end
      else begin m_h = 1; m_v = 1; end
    end else begin
      if (i_cfg_load) begin pend = cin; m_pv = 1; end
      if (m_h >= htot(act)) begin m_h = 1; m_v++; end
      else m_h++;
    end
  endtask

  task automatic check_all();
    int hlo, vlo;
    bit e_de;
    hlo  = act[0] + act[1];
    vlo  = act[4] + act[5];
    e_de = m_run && m_h > hlo && m_h <= hlo + act[2] && m_v > vlo && m_v <= vlo + act[6];
    chk("h_cnt", 32'(o_h_cnt), m_h);
    chk("v_cnt", 32'(o_v_cnt), m_v);
    chk("hsync", 32'(o_hsync), 32'(m_run && m_h <= act[0]));
    chk("vsync", 32'(o_vsync), 32'(m_run && m_v <= act[4]));
    chk("de", 32'(o_de), 32'(e_de));
    chk("line_start", 32'(o_line_start), 32'(m_run && m_h == 1));
    chk("frame_start", 32'(o_frame_start), 32'(m_run && m_h == 1 && m_v == 1));
    chk("busy", 32'(o_busy), 32'(m_run));
    chk("frame_cnt", 32'(o_frame_cnt), m_fc % 256);
    chk("cfg_err", 32'(o_cfg_err), 32'(!valid(act)));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    i_cfg_load = 1'b0;
    check_all();
  endtask

  task automatic load(input int c[8]);
    cin = c;
    i_cfg_load = 1'b1;
    cyc();
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int k = 0; k < 3000 && !(m_run && m_h == h && m_v == v); k++) cyc();
    chk("reach_h", 32'(o_h_cnt), h);
    chk("reach_v", 32'(o_v_cnt), v);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && m_run; k++) cyc();
    chk("reach_idle", 32'(o_busy), 0);
  endtask

  task automatic rand_cfg(input bit must_be_valid, output int c[8]);
    if (must_be_valid) begin
      c[0] = $urandom_range(1, 4); c[1] = $urandom_range(0, 3);
      c[2] = $urandom_range(1, 5); c[3] = $urandom_range(2, 4);
      c[4] = $urandom_range(1, 2); c[5] = $urandom_range(0, 2);
      c[6] = $urandom_range(1, 3); c[7] = $urandom_range(1, 2);
    end else begin
      for (int i = 0; i < 8; i++) c[i] = $urandom_range(0, 4);
    end
  endtask

  initial begin
    int bas[8], c2[8], mini[8], rc[8];
    int cnt_de, cnt_vs, cnt_fs, k;
    bit saw_wrap;
    bas  = '{1, 1, 4, 2, 1, 1, 2, 1};
    mini = '{1, 0, 1, 2, 1, 0, 1, 0};
    for (int i = 0; i < 8; i++) cin[i] = 0;
    model_reset();

    // Reset state: zeroed config is invalid
    #3;
    check_all();
    #4 resetn = 1'b1;

    // Enable and load in the same idle cycle: start judged on the old (invalid) config
    i_enable = 1'b1;
    load(bas);
    chk("same_cycle_no_start", 32'(o_busy), 0);
    cyc();
    chk("start_latency", 32'(o_frame_start), 1);

    // Basic frame: 40 cycles, 8 vsync cycles, 8 de cycles, one frame_start
    cnt_de = 0; cnt_vs = 0; cnt_fs = 0;
    for (int i = 0; i < 40; i++) begin
      cnt_de += int'(o_de); cnt_vs += int'(o_vsync); cnt_fs += int'(o_frame_start);
      cyc();
    end
    chk("de_per_frame", cnt_de, 8);
    chk("vs_per_frame", cnt_vs, 8);
    chk("fs_per_frame", cnt_fs, 1);
    chk("fs_period", 32'(o_frame_start), 1);

    // Stop at v=2,h=5: frame completes (27 more cycles) then idle
    wait_pos(5, 2);
    i_enable = 1'b0;
    k = 0;
    while (o_busy && k < 100) begin cyc(); k++; end
    chk("stop_cycles", k, 28);
    chk("stop_frame_cnt", 32'(o_frame_cnt), 2);

    // Re-raise enable before frame end: no gap into the next frame
    i_enable = 1'b1;
    cyc();
    wait_pos(5, 2);
    i_enable = 1'b0;
    repeat (3) cyc();
    i_enable = 1'b1;
    wait_pos(8, 5);
    cyc();
    chk("no_gap_fs", 32'(o_frame_start), 1);

    // Reconfigure mid-frame twice; last load wins at next frame
    wait_pos(4, 2);
    c2 = bas; c2[2] = 3;
    load(c2);
    cyc();
    c2[2] = 6;
    load(c2);
    wait_pos(1, 1);
    cnt_de = 0;
    for (int i = 0; i < 50; i++) begin cnt_de += int'(o_de); cyc(); end
    chk("de_per_frame_new", cnt_de, 12);
    chk("fs_period_new", 32'(o_frame_start), 1);

    // Invalid config loaded while running: halts at frame end despite enable
    repeat (3) cyc();
    c2 = bas; c2[6] = 0;
    load(c2);
    wait_idle();
    chk("halt_cfg_err", 32'(o_cfg_err), 1);
    repeat (3) cyc();
    chk("halt_stays_idle", 32'(o_busy), 0);

    // Invalid config loaded in idle, then enable: no start
    i_enable = 1'b0;
    load(c2);
    i_enable = 1'b1;
    repeat (5) cyc();
    chk("invalid_idle_busy", 32'(o_busy), 0);
    chk("invalid_idle_err", 32'(o_cfg_err), 1);

    // Frame counter wrap with the smallest legal frame (8 cycles)
    load(mini);
    saw_wrap = 0;
    for (int i = 0; i < 256 * 8 + 16; i++) begin
      k = int'(o_frame_cnt);
      cyc();
      if (k == 255 && o_frame_cnt == 8'd0) saw_wrap = 1;
    end
    chk("frame_cnt_wrap", 32'(saw_wrap), 1);

    // Asynchronous reset mid-frame
    i_enable = 1'b0;
    wait_idle();
    load(bas);
    i_enable = 1'b1;
    wait_pos(4, 3);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    i_enable = 1'b0;
    check_all();
    chk("async_rst_de", 32'(o_de), 0);
    #2 resetn = 1'b1;

    // Randomized enable/load traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 29) == 0) begin
        rand_cfg(!m_run, rc);
        cin = rc;
        i_cfg_load = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
